// File: rtl/nuclei_icb_addr_split_if.sv
// ICB bus bundle: command channel (master -> slave) plus response channel (slave -> master).
interface nuclei_icb_addr_split_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned MW = DW / 8;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/nuclei_icb_addr_split.sv
// Address-decoded 1:2 ICB splitter. Commands go to the target port T when the
// masked address matches the region base, otherwise to the default port D.
// Responses stay in order because the active port may only change while
// nothing is outstanding, so no reorder storage is needed.
module nuclei_icb_addr_split #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned OSTD   = 4,
    parameter logic [31:0] T_BASE = 32'h1000_0000,
    parameter logic [31:0] T_MASK = 32'hF000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    nuclei_icb_addr_split_if.slave   i_icb,
    nuclei_icb_addr_split_if.master  t_icb,
    nuclei_icb_addr_split_if.master  d_icb
);
    localparam int unsigned   CW     = $clog2(OSTD + 1);
    localparam logic [AW-1:0] MASK_A = AW'(T_MASK);
    localparam logic [AW-1:0] BASE_A = AW'(T_BASE & T_MASK);
    localparam logic [CW-1:0] OSTD_C = CW'(OSTD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cur_port_q, cur_port_d;     // 1 = T, 0 = D

    logic          hit_c;
    logic          allow_c;
    logic          cmd_hs_c;
    logic          rsp_hs_c;
    logic [DW-1:0] rsp_rdata_c;

    // Decode, command gating and fan-out; payload passes straight through to both ports
    always_comb begin
        hit_c    = ((i_icb.cmd_addr & MASK_A) == BASE_A);
        allow_c  = (cnt_q == '0) || ((cnt_q < OSTD_C) && (hit_c == cur_port_q));

        t_icb.cmd_addr  = i_icb.cmd_addr;
        t_icb.cmd_read  = i_icb.cmd_read;
        t_icb.cmd_wdata = i_icb.cmd_wdata;
        t_icb.cmd_wmask = i_icb.cmd_wmask;
        d_icb.cmd_addr  = i_icb.cmd_addr;
        d_icb.cmd_read  = i_icb.cmd_read;
        d_icb.cmd_wdata = i_icb.cmd_wdata;
        d_icb.cmd_wmask = i_icb.cmd_wmask;

        t_icb.cmd_valid = i_icb.cmd_valid & allow_c & hit_c;
        d_icb.cmd_valid = i_icb.cmd_valid & allow_c & ~hit_c;
        i_icb.cmd_ready = allow_c & (hit_c ? t_icb.cmd_ready : d_icb.cmd_ready);
        cmd_hs_c        = i_icb.cmd_valid & i_icb.cmd_ready;
    end

    // Response mux follows the port of the most recently accepted command
    always_comb begin
        i_icb.rsp_valid = d_icb.rsp_valid;
        i_icb.rsp_err   = d_icb.rsp_err;
        rsp_rdata_c     = d_icb.rsp_rdata;
        t_icb.rsp_ready = 1'b0;
        d_icb.rsp_ready = 1'b0;
        if (cur_port_q) begin
            i_icb.rsp_valid = t_icb.rsp_valid;
            i_icb.rsp_err   = t_icb.rsp_err;
            rsp_rdata_c     = t_icb.rsp_rdata;
            t_icb.rsp_ready = i_icb.rsp_ready;
        end else begin
            d_icb.rsp_ready = i_icb.rsp_ready;
        end
        i_icb.rsp_rdata = rsp_rdata_c;
        rsp_hs_c        = i_icb.rsp_valid & i_icb.rsp_ready;
    end

    // Outstanding counter (saturates at zero on stray responses) and active-port tracking
    always_comb begin
        cnt_d      = cnt_q;
        cur_port_d = cur_port_q;
        if (cmd_hs_c) begin
            cur_port_d = hit_c;
        end
        case ({cmd_hs_c, rsp_hs_c})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = (cnt_q == '0) ? cnt_q : (cnt_q - CW'(1));
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            cur_port_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cur_port_q <= cur_port_d;
        end
    end
endmodule

// File: tb/tb_nuclei_icb_addr_split.sv
// Bench for nuclei_icb_addr_split: upstream stimulus, a T-region slave model,
// the always-ready zero-data default responder, a per-cycle routing model and
// a response scoreboard.
module tb_nuclei_icb_addr_split;
    localparam int unsigned OSTD = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;

    nuclei_icb_addr_split_if #(.AW(32), .DW(32)) up_if ();
    nuclei_icb_addr_split_if #(.AW(32), .DW(32)) t_if ();
    nuclei_icb_addr_split_if #(.AW(32), .DW(32)) d_if ();

    nuclei_icb_addr_split #(
        .AW(32), .DW(32), .OSTD(OSTD),
        .T_BASE(32'h1000_0000), .T_MASK(32'hF000_0000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_icb (up_if),
        .t_icb (t_if),
        .d_icb (d_if)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    bit   oq[$];
    bit   last_port = 1'b0;
    bit   rnd       = 1'b0;
    bit   t_hold    = 1'b0;
    bit   spur_req  = 1'b0;
    bit   spur_mode = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    function automatic bit is_t(input logic [31:0] a);
        return a[31:28] == 4'h1;
    endfunction

    function automatic logic [31:0] tdata(input logic [31:0] a);
        if (a == 32'h1000_0040) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic terr(input logic [31:0] a);
        return a[3] & a[4] & a[9];
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int k;
        a = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0:       a = 32'h1000_0000;
            1:       a = 32'h1FFF_FFFC;
            2:       a = 32'h0FFF_FFFC;
            3:       a = 32'h2000_0000;
            4, 5, 6: a[31:28] = 4'h1;
            default: if (a[31:28] == 4'h1) a[31:28] = 4'h3;
        endcase
        return a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one command and hold it until accepted; called just after a rising edge
    task automatic send(input logic [31:0] addr, input logic rd, output int waited);
        bit done;
        up_if.cmd_valid = 1'b1;
        up_if.cmd_addr  = addr;
        up_if.cmd_read  = rd;
        up_if.cmd_wdata = $urandom;
        up_if.cmd_wmask = 4'($urandom);
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (up_if.cmd_ready) begin
                done = 1'b1;
                if (is_t(addr)) sb.push_back('{rdata: tdata(addr), err: terr(addr)});
                else            sb.push_back('{rdata: 32'h0, err: 1'b0});
            end else begin
                waited++;
                if (waited > 200) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL cmd_accept: got no handshake want handshake for addr 0x%08h", addr);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        up_if.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending responses want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Target-region slave: accepts commands, answers in order, earliest the next cycle
    initial begin : t_slave
        logic [31:0] tq[$];
        bit t_hs;
        t_if.cmd_ready = 1'b1;
        t_if.rsp_valid = 1'b0;
        t_if.rsp_err   = 1'b0;
        t_if.rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            t_hs = 1'b0;
            if (!rst) begin
                if (t_if.cmd_valid && t_if.cmd_ready) tq.push_back(t_if.cmd_addr);
                if (t_if.rsp_valid && t_if.rsp_ready) begin
                    t_hs = 1'b1;
                    void'(tq.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (!(t_if.rsp_valid && !t_hs)) begin
                t_if.rsp_valid = (tq.size() > 0) && !t_hold && (!rnd || $urandom_range(0, 2) != 0);
                t_if.rsp_rdata = (tq.size() > 0) ? tdata(tq[0]) : 32'h0;
                t_if.rsp_err   = (tq.size() > 0) ? terr(tq[0]) : 1'b0;
            end
            t_if.cmd_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Default responder: always ready, zero data, no error, one response per command
    initial begin : d_slave
        int d_pend;
        d_pend = 0;
        d_if.cmd_ready = 1'b1;
        d_if.rsp_valid = 1'b0;
        d_if.rsp_err   = 1'b0;
        d_if.rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (d_if.cmd_valid && d_if.cmd_ready) d_pend++;
                if (d_if.rsp_valid && d_if.rsp_ready && d_pend > 0) d_pend--;
            end
            @(posedge clk);
            #1;
            d_if.rsp_valid = (d_pend > 0) || spur_req;
        end
    end

    // Upstream response acceptance
    initial begin : up_rsp
        up_if.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            up_if.rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Per-cycle reference: outstanding list of ports, routing, gating and mux selection
    always @(negedge clk) begin : ref_model
        bit h, allow, rv, cmd_hs;
        if (rst) begin
            oq.delete();
            last_port = 1'b0;
        end else begin
            h     = is_t(up_if.cmd_addr);
            allow = (oq.size() == 0) || ((oq.size() < OSTD) && (oq[0] == h));
            rv    = last_port ? t_if.rsp_valid : d_if.rsp_valid;
            chk("outstanding", 64'(dut.cnt_q), 64'(oq.size()));
            chk("i_cmd_ready", 64'(up_if.cmd_ready), 64'(allow & (h ? t_if.cmd_ready : d_if.cmd_ready)));
            chk("t_cmd_valid", 64'(t_if.cmd_valid), 64'(up_if.cmd_valid & allow & h));
            chk("d_cmd_valid", 64'(d_if.cmd_valid), 64'(up_if.cmd_valid & allow & ~h));
            chk("t_cmd_addr", 64'(t_if.cmd_addr), 64'(up_if.cmd_addr));
            chk("d_cmd_wdata", 64'(d_if.cmd_wdata), 64'(up_if.cmd_wdata));
            chk("t_cmd_wmask", 64'(t_if.cmd_wmask), 64'(up_if.cmd_wmask));
            chk("d_cmd_read", 64'(d_if.cmd_read), 64'(up_if.cmd_read));
            chk("i_rsp_valid", 64'(up_if.rsp_valid), 64'(rv));
            chk("t_rsp_ready", 64'(t_if.rsp_ready), 64'(last_port & up_if.rsp_ready));
            chk("d_rsp_ready", 64'(d_if.rsp_ready), 64'(~last_port & up_if.rsp_ready));
            cmd_hs = up_if.cmd_valid && allow && (h ? t_if.cmd_ready : d_if.cmd_ready);
            if (rv && up_if.rsp_ready && oq.size() > 0) void'(oq.pop_front());
            if (cmd_hs) begin
                oq.push_back(h);
                last_port = h;
            end
        end
    end

    // Scoreboard monitor: every upstream response handshake pops one expectation
    always @(negedge clk) begin : sb_monitor
        exp_t e;
        if (rst) begin
            sb.delete();
        end else if (up_if.rsp_valid && up_if.rsp_ready) begin
            if (sb.size() == 0) begin
                if (spur_mode) begin
                    chk("stray_rsp_rdata", 64'(up_if.rsp_rdata), 64'h0);
                end else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_order: got response rdata 0x%08h want no response", up_if.rsp_rdata);
                end
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", 64'(up_if.rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(up_if.rsp_err), 64'(e.err));
            end
        end
    end

    initial begin : stim
        int w, w3;
        rst = 1'b1;
        up_if.cmd_valid = 1'b1;
        up_if.cmd_addr  = 32'h1000_0000;
        up_if.cmd_read  = 1'b1;
        up_if.cmd_wdata = 32'h0;
        up_if.cmd_wmask = 4'h0;

        // Outputs follow the combinational rules with an empty counter during reset
        #12;
        chk("rst_cnt", 64'(dut.cnt_q), 64'h0);
        chk("rst_t_valid", 64'(t_if.cmd_valid), 64'h1);
        chk("rst_d_valid", 64'(d_if.cmd_valid), 64'h0);
        chk("rst_cmd_ready", 64'(up_if.cmd_ready), 64'h1);
        up_if.cmd_addr = 32'h2000_0000;
        #1;
        chk("rst_d_route", 64'(d_if.cmd_valid), 64'h1);
        chk("rst_rsp_valid", 64'(up_if.rsp_valid), 64'h0);
        up_if.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single T read answered the next cycle
        send(32'h1000_0040, 1'b1, w);
        drain();

        // Write to the default region
        send(32'h2000_0000, 1'b0, w);
        drain();

        // Three T reads with responses held back: third stalls at the limit
        t_hold = 1'b1;
        fork
            begin
                send(32'h1000_0100, 1'b1, w);
                send(32'h1000_0104, 1'b1, w);
                send(32'h1000_0108, 1'b1, w3);
            end
            begin
                repeat (5) begin @(posedge clk); #1; end
                t_hold = 1'b0;
            end
        join
        chk("third_stalled", 64'(w3 > 2), 64'h1);
        drain();

        // T outstanding, then a D write waits for the port to drain
        t_hold = 1'b1;
        fork
            begin
                send(32'h1000_0040, 1'b1, w);
                send(32'h3000_0010, 1'b0, w3);
            end
            begin
                repeat (4) begin @(posedge clk); #1; end
                t_hold = 1'b0;
            end
        join
        chk("d_after_t_stalled", 64'(w3 > 0), 64'h1);
        drain();

        // Back-to-back T reads: accept and retire in the same cycle at one outstanding
        send(32'h1000_0200, 1'b1, w);
        send(32'h1000_0204, 1'b1, w);
        drain();

        // Stray response with nothing outstanding must not wrap the counter
        spur_mode = 1'b1;
        spur_req  = 1'b1;
        w = 0;
        while (!(up_if.rsp_valid && up_if.rsp_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        spur_req = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        spur_mode = 1'b0;
        chk("stray_cnt", 64'(dut.cnt_q), 64'h0);
        send(32'h1000_0300, 1'b1, w);
        drain();

        // Randomized traffic with random backpressure and response delays
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(rand_addr(), 1'($urandom), w);
        end
        drain();
        rnd = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Asynchronous reset with two T reads outstanding
        t_hold = 1'b1;
        send(32'h1000_0400, 1'b1, w);
        send(32'h1000_0404, 1'b1, w);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cnt", 64'(dut.cnt_q), 64'h0);
        chk("async_rst_port", 64'(dut.cur_port_q), 64'h0);
        chk("async_rst_ready", 64'(up_if.cmd_ready), 64'h1);
        t_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h2000_0040, 1'b0, w);
        chk("post_rst_accept", 64'(w), 64'h0);
        drain();
        repeat (3) begin @(posedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/nuclei_icb_addr_split.md
NUCLEI_ICB_ADDR_SPLIT -- requirements
Module: nuclei_icb_addr_split

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits (multiple of 8).
REQ-003 Parameter OSTD, default 4, maximum outstanding transactions (1..15).
REQ-004 Parameter T_BASE, default 32'h1000_0000, target region base address.
REQ-005 Parameter T_MASK, default 32'hF000_0000, target region compare mask.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 i_icb_cmd_valid/ready/addr/read/wdata/wmask  in/out/in/in/in/in  1/1/AW/1/DW/DW/8  upstream ICB command channel.
REQ-009 i_icb_rsp_valid/ready/err/rdata  out/in/out/out  1/1/1/DW  upstream ICB response channel.
REQ-010 t_icb_cmd_* and t_icb_rsp_*  mirrored directions and widths of REQ-008/009  target-region slave port.
REQ-011 d_icb_cmd_* and d_icb_rsp_*  mirrored directions and widths  default-slave port (fed to the always-ready, zero-data default responder).

Function
REQ-012 hit = ((i_icb_cmd_addr & T_MASK) == (T_BASE & T_MASK)); hit selects port T, otherwise port D.
REQ-013 addr, read, wdata, wmask SHALL be driven unmodified, combinationally, to both ports; only valid is qualified per port.
REQ-014 State: cnt (outstanding count, width clog2(OSTD+1)), cur_port (1 bit, T=1/D=0).
REQ-015 allow = (cnt == 0) | ((cnt < OSTD) & (hit == cur_port)).
REQ-016 t_icb_cmd_valid = i_icb_cmd_valid & allow & hit; d_icb_cmd_valid = i_icb_cmd_valid & allow & ~hit.
REQ-017 i_icb_cmd_ready = allow & (hit ? t_icb_cmd_ready : d_icb_cmd_ready); zero added latency on the command path.
REQ-018 Port switch SHALL only occur when cnt == 0, guaranteeing in-order responses without reorder storage.
REQ-019 cmd_hs = i_icb_cmd_valid & i_icb_cmd_ready; on cmd_hs cur_port <= hit.
REQ-020 Response mux: i_icb_rsp_valid/err/rdata taken from the port selected by cur_port; the other port's rsp_valid is ignored.
REQ-021 Selected port rsp_ready = i_icb_rsp_ready; unselected port rsp_ready = 0.
REQ-022 rsp_hs = i_icb_rsp_valid & i_icb_rsp_ready.
REQ-023 cnt: +1 on cmd_hs only; -1 on rsp_hs only; unchanged when both occur in the same cycle.
REQ-024 Full (cnt == OSTD): i_icb_cmd_ready = 0 and both cmd_valid outputs = 0 until a response retires; simultaneous rsp_hs does not reopen the command path in that same cycle.
REQ-025 Response in same cycle as cmd to opposite port at cnt==1: command blocked that cycle (cnt not yet 0), accepted next cycle.
REQ-026 Response with cnt == 0 is a protocol error; cnt SHALL saturate at 0 (no wrap); upstream response still passed through.
REQ-027 cnt SHALL never exceed OSTD under any input sequence.
REQ-028 i_icb_rsp_err is passed through; block generates no errors itself.

Reset
REQ-029 On rst high, asynchronously: cnt = 0, cur_port = 0 (D).
REQ-030 During and after reset, outputs follow the combinational rules with cnt = 0: cmd path open, response mux on port D.
REQ-031 Reset mid-transaction discards outstanding tracking; late responses from T are not forwarded until a new T command is issued.

Verification (T_BASE=0x1000_0000, T_MASK=0xF000_0000, OSTD=2)
REQ-032 Read 0x1000_0040, T answers rdata 0xDEAD_BEEF next cycle -> only t_icb_cmd_valid asserted; upstream sees rdata 0xDEAD_BEEF, err 0; cnt 0->1->0.
REQ-033 Write 0x2000_0000 -> routed to D; upstream rsp rdata 0x0, err 0 one cycle later.
REQ-034 Three back-to-back T reads, T rsp_valid held low -> first two accepted, third stalled with i_icb_cmd_ready=0 at cnt=2; released the cycle after the first response retires.
REQ-035 T read outstanding, then D write presented -> D write stalled until T response handshakes, accepted next cycle; responses returned in order T then D.
REQ-036 cnt=1, cmd_hs and rsp_hs in same cycle on port T -> cnt stays 1.
REQ-037 rst asserted with cnt=2 -> cnt=0, cur_port=D immediately (no clock edge needed); new D command accepted in first cycle after rst falls.
